fifo_sync_banked: RTL and testbench

Single-clock, parametrised FIFO built on a banked 1W1R memory with registered read ports. It has two read modes: standard (data one cycle after read accept) and first-word-fall-through (FWFT). It also provides an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Use it for same-clock buffering wherever the dual-clock Gray-pointer FIFO is not needed.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_bank_mem.sv | 52 +++++
 rtl/fifo_sync_banked.sv | 102 ++++++++++
 tb/tb_fifo_sync_banked.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and derived-constant helpers for the banked synchronous FIFO.
package fifo_pkg;

    typedef enum logic {RD_STD, RD_FWFT} read_mode_e;

    function automatic int depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic int nbanks(input int asize, input int bsize);
        return 1 << (asize - bsize);
    endfunction

    // Legal iff banks fit inside the address space and thresholds are ordered.
    function automatic bit params_ok(input int asize, input int bsize,
                                     input int afull_th, input int aempty_th);
        return (bsize >= 1) && (bsize <= asize) &&
               (aempty_th < afull_th) && (afull_th <= depth(asize));
    endfunction

endpackage

// File: rtl/fifo_bank_mem.sv
// Banked 1W1R memory: one-hot bank decode, registered per-bank read, output mux
// steered by a registered bank select.
module fifo_bank_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 12,
    parameter int BSIZE = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int NB = nbanks(ASIZE, BSIZE);
    localparam int BD = 1 << BSIZE;
    localparam int BW = (ASIZE > BSIZE) ? (ASIZE - BSIZE) : 1;

    logic [BW-1:0]    wbank, rbank, rbank_q;
    logic [BSIZE-1:0] wrow, rrow;
    logic [NB-1:0]    wsel, rsel;
    logic [DSIZE-1:0] mem [NB][BD];
    logic [DSIZE-1:0] rq  [NB];

    always_comb begin
        wbank = BW'(waddr >> BSIZE);
        rbank = BW'(raddr >> BSIZE);
        wrow  = waddr[BSIZE-1:0];
        rrow  = raddr[BSIZE-1:0];
        wsel  = '0;
        rsel  = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            wsel[b] = we && (wbank == BW'(b));
            rsel[b] = re && (rbank == BW'(b));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (wsel[b]) mem[b][wrow] <= wdata;
            if (rsel[b]) rq[b] <= mem[b][rrow];
        end
        if (re) rbank_q <= rbank;
    end

    always_comb rdata = rq[rbank_q];

endmodule

// File: rtl/fifo_sync_banked.sv
// Single-clock FIFO over banked memory: pointers, occupancy, flags, and the
// FWFT fetch control that keeps the bank output register loaded with the head.
module fifo_sync_banked
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 16,
    parameter int ASIZE     = 12,
    parameter int BSIZE     = 7,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = depth(ASIZE) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW = ASIZE + 1;
    localparam read_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth(ASIZE));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    if (!params_ok(ASIZE, BSIZE, AFULL_TH, AEMPTY_TH)) begin : g_param_check
        $error("fifo_sync_banked: illegal ASIZE/BSIZE/threshold combination");
    end

    logic [CW-1:0]    wptr, rptr, mem_cnt, count_next;
    logic             wr_acc, rd_acc, fetch, rd_issue, rvalid_next;
    logic [DSIZE-1:0] mem_rdata;

    // rptr tracks memory reads issued, so wptr - rptr is the unfetched backlog.
    always_comb begin
        mem_cnt  = wptr - rptr;
        wr_acc   = winc && !wfull;
        rd_acc   = rinc && !rempty;
        fetch    = (!rvalid || rd_acc) && (mem_cnt != '0);
        rd_issue = (MODE == RD_FWFT) ? fetch : rd_acc;

        count_next = count;
        if (wr_acc && !rd_acc)      count_next = count + ONE;
        else if (!wr_acc && rd_acc) count_next = count - ONE;

        if (MODE == RD_FWFT) rvalid_next = fetch || (rvalid && !rd_acc);
        else                 rvalid_next = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rvalid        <= 1'b0;
            wfull         <= 1'b0;
            walmost_full  <= (AFULL_TH == 0);
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_acc)   wptr <= wptr + ONE;
            if (rd_issue) rptr <= rptr + ONE;
            count         <= count_next;
            rvalid        <= rvalid_next;
            wfull         <= (count_next == DEPTH_C);
            walmost_full  <= (count_next >= AFULL_C);
            ralmost_empty <= (count_next <= AEMPTY_C);
            rempty        <= (MODE == RD_FWFT) ? !rvalid_next : (count_next == '0);
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    fifo_bank_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .BSIZE (BSIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .re    (rd_issue),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (mem_rdata)
    );

    always_comb rdata = rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_fifo_sync_banked.sv
// Scoreboarded bench for fifo_sync_banked: one standard-mode and one FWFT
// instance (DEPTH=16, 4 banks) driven in turn with directed sequences.
module tb_fifo_sync_banked;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, winc, rinc;
    logic [1:0][15:0] wdata, rdata;
    logic [1:0]       wfull, walmost_full, rvalid, rempty, ralmost_empty;
    logic [1:0]       overflow, underflow;
    logic [1:0][4:0]  count;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    fifo_sync_banked #(
        .DSIZE(16), .ASIZE(4), .BSIZE(2), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) u_std (
        .clk(clk), .rst(rst[0]), .winc(winc[0]), .wdata(wdata[0]),
        .wfull(wfull[0]), .walmost_full(walmost_full[0]), .rinc(rinc[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0]), .rempty(rempty[0]),
        .ralmost_empty(ralmost_empty[0]), .count(count[0]),
        .overflow(overflow[0]), .underflow(underflow[0])
    );

    fifo_sync_banked #(
        .DSIZE(16), .ASIZE(4), .BSIZE(2), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) u_fwft (
        .clk(clk), .rst(rst[1]), .winc(winc[1]), .wdata(wdata[1]),
        .wfull(wfull[1]), .walmost_full(walmost_full[1]), .rinc(rinc[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1]), .rempty(rempty[1]),
        .ralmost_empty(ralmost_empty[1]), .count(count[1]),
        .overflow(overflow[1]), .underflow(underflow[1])
    );

    task automatic chk(input int m, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL m%0d %s: got %0h expected %0h", m, name, act, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    // Standard mode: every rvalid cycle is a delivered word.
    // FWFT: a word is delivered when rvalid and rinc meet outside reset.
    always @(negedge clk) begin
        logic [15:0] e;
        if (armed) begin
            for (int m = 0; m < 2; m++) begin
                if (rvalid[m] && !rst[m] && (m == 0 || rinc[m])) begin
                    if (qsize(m) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL m%0d unexpected_out: got %0h expected no word", m, rdata[m]);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        chk(m, "rdata_order", 32'(rdata[m]), 32'(e));
                    end
                end else if (!rvalid[m]) begin
                    chk(m, "rdata_zero_idle", 32'(rdata[m]), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int m, input logic [15:0] d, input bit accept);
        winc[m]  = 1'b1;
        wdata[m] = d;
        if (accept) begin
            if (m == 0) q0.push_back(d);
            else        q1.push_back(d);
        end
        tick();
        winc[m] = 1'b0;
    endtask

    task automatic drain(input int m, input int n, input int c0);
        rinc[m] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (m == 1) chk(m, "fwft_no_gap", 32'(rvalid[m]), 1);
            tick();
            if (m == 0) chk(m, "std_valid_after_accept", 32'(rvalid[m]), 1);
            chk(m, "drain_count", 32'(count[m]), c0 - k - 1);
            chk(m, "drain_aempty", 32'(ralmost_empty[m]), 32'((c0 - k - 1) <= AE));
        end
        rinc[m] = 1'b0;
        tick();
        chk(m, "valid_low_after_drain", 32'(rvalid[m]), 0);
    endtask

    task automatic run_mode(input int m);
        rst[m] = 1'b1;
        tick();
        rst[m] = 1'b0;
        chk(m, "rst_count", 32'(count[m]), 0);
        chk(m, "rst_rempty", 32'(rempty[m]), 1);
        chk(m, "rst_wfull", 32'(wfull[m]), 0);
        chk(m, "rst_afull", 32'(walmost_full[m]), 0);
        chk(m, "rst_aempty", 32'(ralmost_empty[m]), 1);
        chk(m, "rst_rvalid", 32'(rvalid[m]), 0);
        chk(m, "rst_rdata", 32'(rdata[m]), 0);
        chk(m, "rst_overflow", 32'(overflow[m]), 0);
        chk(m, "rst_underflow", 32'(underflow[m]), 0);

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) begin
            wr(m, 16'(i), 1'b1);
            chk(m, "fill_count", 32'(count[m]), i + 1);
            chk(m, "fill_afull", 32'(walmost_full[m]), 32'((i + 1) >= AF));
            chk(m, "fill_wfull", 32'(wfull[m]), 32'((i + 1) == DEPTH));
            chk(m, "fill_aempty", 32'(ralmost_empty[m]), 32'((i + 1) <= AE));
        end
        wr(m, 16'hDEAD, 1'b0);
        chk(m, "ovf_set", 32'(overflow[m]), 1);
        chk(m, "ovf_count", 32'(count[m]), 16);
        chk(m, "ovf_wfull", 32'(wfull[m]), 1);

        drain(m, 16, 16);
        chk(m, "drained_rempty", 32'(rempty[m]), 1);
        chk(m, "drained_underflow", 32'(underflow[m]), 0);
        chk(m, "drained_all_seen", qsize(m), 0);

        // wrap across banks and pointer MSB at steady occupancy 5
        for (int i = 0; i < 5; i++) wr(m, 16'h0100 + 16'(i), 1'b1);
        for (int k = 0; k < 40; k++) begin
            winc[m]  = 1'b1;
            rinc[m]  = 1'b1;
            wdata[m] = 16'h0200 + 16'(k);
            if (m == 0) q0.push_back(wdata[m]);
            else        q1.push_back(wdata[m]);
            tick();
            chk(m, "wrap_count", 32'(count[m]), 5);
        end
        winc[m] = 1'b0;
        rinc[m] = 1'b0;
        drain(m, 5, 5);

        // simultaneous read/write at full and at empty
        for (int i = 0; i < DEPTH; i++) wr(m, 16'h0300 + 16'(i), 1'b1);
        winc[m]  = 1'b1;
        rinc[m]  = 1'b1;
        wdata[m] = 16'hDEAD;
        tick();
        winc[m] = 1'b0;
        rinc[m] = 1'b0;
        chk(m, "full_rw_count", 32'(count[m]), 15);
        chk(m, "full_rw_overflow", 32'(overflow[m]), 1);
        chk(m, "full_rw_wfull", 32'(wfull[m]), 0);
        drain(m, 15, 15);
        chk(m, "pre_empty_rw_underflow", 32'(underflow[m]), 0);
        winc[m]  = 1'b1;
        rinc[m]  = 1'b1;
        wdata[m] = 16'h4444;
        if (m == 0) q0.push_back(16'h4444);
        else        q1.push_back(16'h4444);
        tick();
        winc[m] = 1'b0;
        rinc[m] = 1'b0;
        chk(m, "empty_rw_count", 32'(count[m]), 1);
        chk(m, "empty_rw_underflow", 32'(underflow[m]), 1);
        tick();
        drain(m, 1, 1);
        chk(m, "simul_all_seen", qsize(m), 0);

        // write-to-readable latency
        wr(m, 16'h1234, 1'b1);
        chk(m, "lat_rempty_e0", 32'(rempty[m]), (m == 1) ? 1 : 0);
        chk(m, "lat_rvalid_e0", 32'(rvalid[m]), 0);
        tick();
        chk(m, "lat_rempty_e1", 32'(rempty[m]), 0);
        if (m == 1) begin
            chk(m, "lat_rdata_e1", 32'(rdata[m]), 32'h1234);
            chk(m, "lat_rvalid_e1", 32'(rvalid[m]), 1);
            tick();
            tick();
            chk(m, "lat_rdata_hold", 32'(rdata[m]), 32'h1234);
        end
        drain(m, 1, 1);

        // reset mid-operation with winc/rinc asserted
        for (int i = 0; i < 7; i++) wr(m, 16'h0500 + 16'(i), 1'b0);
        chk(m, "pre_rst_count", 32'(count[m]), 7);
        chk(m, "pre_rst_overflow", 32'(overflow[m]), 1);
        chk(m, "pre_rst_underflow", 32'(underflow[m]), 1);
        rst[m]   = 1'b1;
        winc[m]  = 1'b1;
        rinc[m]  = 1'b1;
        wdata[m] = 16'h5555;
        tick();
        rst[m]  = 1'b0;
        winc[m] = 1'b0;
        rinc[m] = 1'b0;
        chk(m, "mid_rst_count", 32'(count[m]), 0);
        chk(m, "mid_rst_rempty", 32'(rempty[m]), 1);
        chk(m, "mid_rst_wfull", 32'(wfull[m]), 0);
        chk(m, "mid_rst_rvalid", 32'(rvalid[m]), 0);
        chk(m, "mid_rst_rdata", 32'(rdata[m]), 0);
        chk(m, "mid_rst_overflow", 32'(overflow[m]), 0);
        chk(m, "mid_rst_underflow", 32'(underflow[m]), 0);
        chk(m, "mid_rst_aempty", 32'(ralmost_empty[m]), 1);
        wr(m, 16'hBEEF, 1'b1);
        tick();
        drain(m, 1, 1);
        chk(m, "post_rst_all_seen", qsize(m), 0);
    endtask

    initial begin
        rst   = 2'b11;
        winc  = 2'b00;
        rinc  = 2'b00;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 2'b00;
        armed = 1'b1;
        for (int m = 0; m < 2; m++) run_mode(m);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
